ysyx_25020047_lsu: RTL and testbench
====================================

Name: ysyx_25020047_lsu

Overview:
- Multi-cycle load/store unit directly downstream of the execute stage.
- Consumes the execute stage's effective address (`result`) and its `read`/`write` strobes, plus store data and an access size.
- Runs one request/grant/response transaction on the data-memory port, then returns zero-extended load data and a done pulse to writeback.
- Non-memory instructions pass through with a one-cycle done and no memory traffic.

Parameters:
- TIMEOUT, 64: max cycles spent waiting for `mem_gnt` or `mem_rvalid` before the access is aborted with error.
- CNT_W, 7: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  LSU can accept (state IDLE)
- addr  in  32  effective address from execute `result`
- read  in  1  load request (lw/lbu)
- write  in  1  store request (sw/sb)
- size_byte  in  1  1 = byte access (lbu/sb), 0 = word (lw/sw)
- wdata  in  32  store data (rs2 value)
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-placed store data
- mem_wmask  out  4  byte-enable mask
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  32  load result, zero-extended; 0 for stores and non-memory ops
- out_err  out  1  misaligned, illegal, or timed-out access; valid with out_valid

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, out_valid=0, out_rdata=0, out_err=0, watchdog=0. in_ready=1 after reset.
- Reset mid-transaction: abort to IDLE next edge; no out_valid is produced. A late mem_gnt or mem_rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE, accepts when in_valid & in_ready, latching addr/read/write/size_byte/wdata:
  - read & write both set -> DONE, out_err=1.
  - Word access (size_byte=0) with addr[1:0]!=0 -> DONE, out_err=1, no mem_req.
  - Neither read nor write -> DONE, out_rdata=0, out_err=0.
  - Otherwise -> REQ.
- REQ:
  - mem_req=1 held until mem_gnt; address, data and mask stay stable while waiting.
  - On mem_gnt: a store -> DONE, a load -> WAIT_R. Watchdog clears.
- WAIT_R:
  - mem_req=0.
  - On mem_rvalid: capture the load result -> DONE.
  - mem_rvalid in the same cycle as mem_gnt is not legal; the memory returns rvalid no earlier than the cycle after gnt.
- Watchdog:
  - Increments each cycle in REQ or WAIT_R; clears on any state change.
  - At count==TIMEOUT-1 with no gnt/rvalid -> DONE, out_err=1, mem_req drops.
- DONE: out_valid=1 for exactly one cycle, in_ready=0, then -> IDLE. out_rdata and out_err hold their values until the next DONE.
- Store lanes:
  - Word: mem_wdata=wdata, mem_wmask=4'b1111.
  - Byte: mem_wdata={4{wdata[7:0]}}, mem_wmask=4'b0001<<addr[1:0].
- Load lanes:
  - Word: out_rdata=mem_rdata.
  - Byte: out_rdata={24'b0, mem_rdata[8*addr[1:0] +: 8]}.
- Latency, inclusive of the accept edge:
  - Non-memory or error: 2 cycles to out_valid.
  - Store with immediate gnt: 3 cycles.
  - Load with gnt then rvalid one cycle later: 4 cycles.
- One outstanding access at a time; in_valid is ignored while in_ready=0.

Test Plan:
- sw: addr=0x80000010, wdata=0xDEADBEEF, gnt in the first REQ cycle -> mem_addr=0x80000010, wmask=1111, wdata=0xDEADBEEF; out_valid 3 cycles after accept; out_err=0.
- sb: addr=0x80000013, wdata=0x000000A5 -> mem_addr=0x80000010, wmask=1000, mem_wdata=0xA5A5A5A5.
- lbu: addr=0x80000022, rdata=0x11C32211 returned 2 cycles after gnt -> out_rdata=0x000000C3; lw at the same word -> out_rdata=0x11C32211.
- lw: addr=0x80000006 -> no mem_req, out_valid after 2 cycles, out_err=1. Non-memory op (read=write=0) -> out_valid, out_rdata=0, out_err=0.
- gnt withheld for TIMEOUT cycles -> mem_req drops, out_valid with out_err=1. Gnt after 5 stall cycles -> normal completion.
- rst asserted in WAIT_R, rvalid arrives the next cycle -> no out_valid, in_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between execute and writeback: one request/grant/response
// transaction per memory instruction, with lane handling and a watchdog.
module ysyx_25020047_lsu #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic        read,
  input  logic        write,
  input  logic        size_byte,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        byte_q, byte_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_err_q, out_err_d;
  logic [7:0]  lane_s;

  // Next-state, watchdog and registered-output computation
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    byte_d      = byte_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    out_valid_d = 1'b0;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    lane_s      = mem_rdata[{off_q, 3'b000} +: 8];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_d = read;
          byte_d = size_byte;
          off_d  = addr[1:0];
          if ((read & write) || (!size_byte && (addr[1:0] != 2'b00))) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_rdata_d = 32'h0000_0000;
            out_err_d   = 1'b1;
          end else if (!(read | write)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_rdata_d = 32'h0000_0000;
            out_err_d   = 1'b0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = write;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = size_byte ? {4{wdata[7:0]}} : wdata;
            mem_wmask_d = size_byte ? (4'b0001 << addr[1:0]) : 4'b1111;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (load_q) begin
            state_d = WAIT_R;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_rdata_d = 32'h0000_0000;
            out_err_d   = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d   = 1'b0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_rdata_d = 32'h0000_0000;
          out_err_d   = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_rdata_d = byte_q ? {24'h00_0000, lane_s} : mem_rdata;
          out_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_rdata_d = 32'h0000_0000;
          out_err_d   = 1'b1;
        end else begin
          state_d = WAIT_R;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Watchdog only runs while parked in a waiting state
    if (((state_q == REQ) || (state_q == WAIT_R)) && (state_d == state_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wmask_q <= 4'b0000;
      out_valid_q <= 1'b0;
      out_rdata_q <= 32'h0000_0000;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      byte_q      <= byte_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for the LSU: expected completions are queued at issue
// and compared (data, error, completion cycle) when out_valid fires.
module tb_ysyx_25020047_lsu;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] addr = 32'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        size_byte = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_cnt = 0;

  ysyx_25020047_lsu #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .read(read), .write(write), .size_byte(size_byte), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard monitor: every completion must match the oldest expectation
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no completion", cyc_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 3;
        if (out_rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_rdata: got %h, required %h", out_rdata, e.rdata);
        end
        if (out_err !== e.err) begin
          errors++;
          $display("FAIL sb_err: got %b, required %b", out_err, e.err);
        end
        if (cyc_cnt != e.cyc) begin
          errors++;
          $display("FAIL sb_latency: done at cycle %0d, required cycle %0d", cyc_cnt, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] rd, input logic err, input int cyc);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  // Present one instruction for exactly one accept edge
  task automatic issue(input logic [31:0] a, input logic r, input logic w,
                       input logic sz, input logic [31:0] d);
    addr = a; read = r; write = w; size_byte = sz; wdata = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic grant(input int g);
    repeat (g) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic respond(input int d, input logic [31:0] data);
    repeat (d - 1) tick();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d completions outstanding, required 0", sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_rdata, out_err} !== 104'h0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h mask=%b ov=%b rd=%h err=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_rdata, out_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_sw();
    push(32'h0, 1'b0, cyc_cnt + 2);
    issue(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    checks += 5;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %b, required 1", mem_req); end
    if (mem_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b, required 1", mem_we); end
    if (mem_addr !== 32'h8000_0010) begin errors++; $display("FAIL sw_addr: got %h, required 80000010", mem_addr); end
    if (mem_wmask !== 4'b1111) begin errors++; $display("FAIL sw_mask: got %b, required 1111", mem_wmask); end
    if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h, required deadbeef", mem_wdata); end
    grant(0);
    wait_drain();
  endtask

  task automatic test_sb();
    push(32'h0, 1'b0, cyc_cnt + 2);
    issue(32'h8000_0013, 1'b0, 1'b1, 1'b1, 32'h0000_00A5);
    checks += 3;
    if (mem_addr !== 32'h8000_0010) begin errors++; $display("FAIL sb_addr: got %h, required 80000010", mem_addr); end
    if (mem_wmask !== 4'b1000) begin errors++; $display("FAIL sb_mask: got %b, required 1000", mem_wmask); end
    if (mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h, required a5a5a5a5", mem_wdata); end
    grant(0);
    wait_drain();
  endtask

  task automatic test_loads();
    push(32'h0000_00C3, 1'b0, cyc_cnt + 4);
    issue(32'h8000_0022, 1'b1, 1'b0, 1'b1, 32'h0);
    checks += 2;
    if (mem_addr !== 32'h8000_0020) begin errors++; $display("FAIL lbu_addr: got %h, required 80000020", mem_addr); end
    if (mem_we !== 1'b0) begin errors++; $display("FAIL lbu_we: got %b, required 0", mem_we); end
    grant(0);
    respond(2, 32'h11C3_2211);
    wait_drain();
    tick();
    checks++;
    if (out_rdata !== 32'h0000_00C3) begin errors++; $display("FAIL lbu_hold: got %h, required 000000c3", out_rdata); end
    push(32'h11C3_2211, 1'b0, cyc_cnt + 3);
    issue(32'h8000_0020, 1'b1, 1'b0, 1'b0, 32'h0);
    grant(0);
    respond(1, 32'h11C3_2211);
    wait_drain();
  endtask

  task automatic test_misaligned_and_nonmem();
    push(32'h0, 1'b1, cyc_cnt + 1);
    issue(32'h8000_0006, 1'b1, 1'b0, 1'b0, 32'h0);
    checks += 2;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL misalign_req: got %b, required 0", mem_req); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL misalign_busy: got in_ready=%b, required 0", in_ready); end
    wait_drain();
    push(32'h0, 1'b0, cyc_cnt + 1);
    issue(32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    wait_drain();
    push(32'h0, 1'b1, cyc_cnt + 1);
    issue(32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0);
    wait_drain();
  endtask

  task automatic test_timeout_and_stall();
    push(32'h0, 1'b1, cyc_cnt + TO + 1);
    issue(32'h8000_0040, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);
    repeat (TO - 1) tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_req_held: got %b, required 1", mem_req); end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL timeout_req_drop: got %b, required 0", mem_req); end
    wait_drain();
    push(32'h0, 1'b0, cyc_cnt + 7);
    issue(32'h8000_0044, 1'b0, 1'b1, 1'b0, 32'h0102_0304);
    repeat (5) begin
      checks += 2;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL stall_req: got %b, required 1", mem_req); end
      if (mem_wdata !== 32'h0102_0304) begin errors++; $display("FAIL stall_wdata: got %h, required 01020304", mem_wdata); end
      tick();
    end
    grant(0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    push(32'h0, 1'b0, cyc_cnt + 5);
    issue(32'h8000_0050, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA);
    in_valid = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b, required 0", in_ready); end
    end
    in_valid = 1'b0;
    grant(0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    issue(32'h8000_0060, 1'b1, 1'b0, 1'b0, 32'h0);
    grant(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    repeat (3) begin
      checks += 2;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", in_ready); end
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, out_rdata, out_err} !== 104'h0) begin
        errors++;
        $display("FAIL rstmid_outputs: got ov=%b rd=%h err=%b req=%b addr=%h, required all 0",
                 out_valid, out_rdata, out_err, mem_req, mem_addr);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_loads();
    test_misaligned_and_nonmem();
    test_timeout_and_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
